// File: rtl/writeback_unit_pkg.sv
// Shared register-file types and the buffered write-back entry.
package definitions;

   typedef logic [4:0]  t_register_index;
   typedef logic [31:0] t_data;

   typedef struct packed {
      t_register_index rd;
      t_data           data;
   } t_wb_entry;

endpackage

// File: rtl/writeback_unit_fifo.sv
// Small synchronous FIFO of write-back entries; full/empty are derived from
// registered pointers, so a pop only frees a slot for the following cycle.
module wb_fifo
   import definitions::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  t_wb_entry push_entry,
   input  logic      pop,
   output t_wb_entry head,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   t_wb_entry     mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Extra pointer bit tells a wrapped-full FIFO apart from an empty one.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
   end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port arbiter (ALU vs. buffered loads) with starvation
// guard, plus the pending-write scoreboard consulted by issue.
module writeback_unit
   import definitions::*;
#(
   parameter int LOAD_FIFO_DEPTH = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_issue_valid,
   input  t_register_index i_issue_rd,
   input  t_register_index i_check_idx1,
   input  t_register_index i_check_idx2,
   output logic            o_busy1,
   output logic            o_busy2,
   input  logic            i_alu_valid,
   input  t_register_index i_alu_rd,
   input  t_data           i_alu_data,
   output logic            o_alu_ready,
   input  logic            i_load_valid,
   input  t_register_index i_load_rd,
   input  t_data           i_load_data,
   output logic            o_load_ready,
   output logic            o_wr_enable,
   output t_register_index o_wr_idx,
   output t_data           o_wr_data
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   t_wb_entry    fifo_head;
   logic         fifo_full;
   logic         fifo_empty;
   logic         alu_grant;
   logic         load_grant;
   t_wb_entry    grant_entry;
   logic [SW-1:0] starve_cnt;
   logic [31:0]  sb;
   logic [31:0]  sb_next;

   wb_fifo #(.DEPTH(LOAD_FIFO_DEPTH)) u_fifo (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .push       (i_load_valid),
      .push_entry ('{rd: i_load_rd, data: i_load_data}),
      .pop        (load_grant),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   assign o_load_ready = !fifo_full;
   assign o_alu_ready  = !(!fifo_empty && starve_cnt == SW'(STARVE_LIMIT));
   assign alu_grant    = i_alu_valid && o_alu_ready;
   assign load_grant   = !alu_grant && !fifo_empty;

   always_comb begin
      grant_entry = fifo_head;
      if (alu_grant) grant_entry = '{rd: i_alu_rd, data: i_alu_data};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         starve_cnt <= '0;
      end else if (fifo_empty || load_grant) begin
         starve_cnt <= '0;
      end else if (alu_grant && starve_cnt != SW'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   // Writes to r0 are consumed silently; index/data keep their last real value.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wr_enable <= 1'b0;
         o_wr_idx    <= '0;
         o_wr_data   <= '0;
      end else begin
         o_wr_enable <= 1'b0;
         if ((alu_grant || load_grant) && grant_entry.rd != '0) begin
            o_wr_enable <= 1'b1;
            o_wr_idx    <= grant_entry.rd;
            o_wr_data   <= grant_entry.data;
         end
      end
   end

   // Set after clear so a same-edge re-issue keeps the register pending.
   always_comb begin
      sb_next = sb;
      if (o_wr_enable)   sb_next[o_wr_idx]   = 1'b0;
      if (i_issue_valid) sb_next[i_issue_rd] = 1'b1;
      sb_next[0] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) sb <= '0;
      else          sb <= sb_next;
   end

   assign o_busy1 = sb[i_check_idx1];
   assign o_busy2 = sb[i_check_idx2];

endmodule

// File: tb/tb_writeback_unit.sv
// Directed vector bench for writeback_unit: arbitration, starvation, FIFO
// backpressure, r0 handling, scoreboard set/clear races and async reset.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid;
   logic [4:0]  issue_rd, check1, check2;
   logic        busy1, busy2;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        load_valid;
   logic [4:0]  load_rd;
   logic [31:0] load_data;
   logic        load_ready;
   logic        wr_en;
   logic [4:0]  wr_idx;
   logic [31:0] wr_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   writeback_unit #(.LOAD_FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_issue_valid(issue_valid),
      .i_issue_rd   (issue_rd),
      .i_check_idx1 (check1),
      .i_check_idx2 (check2),
      .o_busy1      (busy1),
      .o_busy2      (busy2),
      .i_alu_valid  (alu_valid),
      .i_alu_rd     (alu_rd),
      .i_alu_data   (alu_data),
      .o_alu_ready  (alu_ready),
      .i_load_valid (load_valid),
      .i_load_rd    (load_rd),
      .i_load_data  (load_data),
      .o_load_ready (load_ready),
      .o_wr_enable  (wr_en),
      .o_wr_idx     (wr_idx),
      .o_wr_data    (wr_data)
   );

   typedef struct {
      logic        av;  logic [4:0] ard; logic [31:0] adat;
      logic        lv;  logic [4:0] lrd; logic [31:0] ldat;
      logic        iv;  logic [4:0] ird;
      logic [4:0]  c1;  logic [4:0] c2;
      logic        e_ar; logic e_lr; logic e_b1; logic e_b2;
      logic        e_en; logic [4:0] e_idx; logic [31:0] e_dat;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic iv, input logic [4:0] ird, input logic [4:0] c1, input logic [4:0] c2,
                      input logic ar, input logic lr, input logic b1, input logic b2,
                      input logic en, input logic [4:0] idx, input logic [31:0] dat);
      vec_t v;
      v.av = av; v.ard = ard; v.adat = adat; v.lv = lv; v.lrd = lrd; v.ldat = ldat;
      v.iv = iv; v.ird = ird; v.c1 = c1; v.c2 = c2;
      v.e_ar = ar; v.e_lr = lr; v.e_b1 = b1; v.e_b2 = b2;
      v.e_en = en; v.e_idx = idx; v.e_dat = dat;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      issue_valid = 0; issue_rd = 0; check1 = 0; check2 = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      load_valid = 0; load_rd = 0; load_data = 0;
   endtask

   initial begin
      idle_inputs();
      rst_n = 0;

      //    av ard adat           lv lrd ldat   iv ird c1 c2  ar lr b1 b2  en idx dat
      add(1, 5, 32'hDEADBEEF, 0, 0, 0,       0, 0, 5, 0,  1, 1, 0, 0,  1, 5, 32'hDEADBEEF);
      add(0, 0, 0,            0, 0, 0,       0, 0, 0, 0,  1, 1, 0, 0,  0, 5, 32'hDEADBEEF);
      add(0, 0, 0,            0, 0, 0,       1, 7, 7, 0,  1, 1, 0, 0,  0, 5, 32'hDEADBEEF);
      add(0, 0, 0,            0, 0, 0,       0, 0, 7, 0,  1, 1, 1, 0,  0, 5, 32'hDEADBEEF);
      add(0, 0, 0,            0, 0, 0,       0, 0, 7, 0,  1, 1, 1, 0,  0, 5, 32'hDEADBEEF);
      add(0, 0, 0,            1, 7, 'h1234,  0, 0, 7, 0,  1, 1, 1, 0,  0, 5, 32'hDEADBEEF);
      add(0, 0, 0,            0, 0, 0,       0, 0, 7, 0,  1, 1, 1, 0,  1, 7, 'h1234);
      add(0, 0, 0,            0, 0, 0,       0, 0, 7, 0,  1, 1, 1, 0,  0, 7, 'h1234);
      add(0, 0, 0,            0, 0, 0,       0, 0, 7, 0,  1, 1, 0, 0,  0, 7, 'h1234);
      // one load pending under continuous ALU traffic
      add(1, 1, 'h11,         1, 2, 'h22,    0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 'h11);
      add(1, 1, 'h12,         0, 0, 0,       0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 'h12);
      add(1, 1, 'h13,         0, 0, 0,       0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 'h13);
      add(1, 1, 'h14,         0, 0, 0,       0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 'h14);
      add(1, 1, 'h15,         0, 0, 0,       0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 'h15);
      add(1, 1, 'h16,         0, 0, 0,       0, 0, 0, 0,  0, 1, 0, 0,  1, 2, 'h22);
      add(1, 1, 'h16,         0, 0, 0,       0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 'h16);
      // fill the FIFO, third load held until a pop, order preserved
      add(1, 3, 'h30,         1, 4, 'h40,    0, 0, 0, 0,  1, 1, 0, 0,  1, 3, 'h30);
      add(1, 3, 'h31,         1, 5, 'h50,    0, 0, 0, 0,  1, 1, 0, 0,  1, 3, 'h31);
      add(1, 3, 'h32,         1, 6, 'h60,    0, 0, 0, 0,  1, 0, 0, 0,  1, 3, 'h32);
      add(1, 3, 'h33,         1, 6, 'h60,    0, 0, 0, 0,  1, 0, 0, 0,  1, 3, 'h33);
      add(1, 3, 'h34,         1, 6, 'h60,    0, 0, 0, 0,  1, 0, 0, 0,  1, 3, 'h34);
      add(1, 3, 'h35,         1, 6, 'h60,    0, 0, 0, 0,  0, 0, 0, 0,  1, 4, 'h40);
      add(1, 3, 'h35,         1, 6, 'h60,    0, 0, 0, 0,  1, 1, 0, 0,  1, 3, 'h35);
      add(0, 0, 0,            0, 0, 0,       0, 0, 0, 0,  1, 0, 0, 0,  1, 5, 'h50);
      add(0, 0, 0,            0, 0, 0,       0, 0, 0, 0,  1, 1, 0, 0,  1, 6, 'h60);
      add(0, 0, 0,            0, 0, 0,       0, 0, 0, 0,  1, 1, 0, 0,  0, 6, 'h60);
      // r0: accepted but never written, never busy
      add(1, 0, 32'hFFFFFFFF, 0, 0, 0,       1, 0, 0, 0,  1, 1, 0, 0,  0, 6, 'h60);
      add(0, 0, 0,            0, 0, 0,       0, 0, 0, 0,  1, 1, 0, 0,  0, 6, 'h60);
      // clear and set of r9 on the same edge
      add(0, 0, 0,            0, 0, 0,       1, 9, 9, 7,  1, 1, 0, 0,  0, 6, 'h60);
      add(1, 9, 'h99,         0, 0, 0,       0, 0, 9, 0,  1, 1, 1, 0,  1, 9, 'h99);
      add(0, 0, 0,            0, 0, 0,       1, 9, 9, 0,  1, 1, 1, 0,  0, 9, 'h99);
      add(0, 0, 0,            0, 0, 0,       0, 0, 9, 9,  1, 1, 1, 1,  0, 9, 'h99);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_wr_en",   wr_en, 0);
      chk("rst_wr_idx",  wr_idx, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_alu_rdy", alu_ready, 1);
      chk("rst_load_rdy", load_ready, 1);
      chk("rst_busy1",   busy1, 0);
      rst_n = 1;

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         string tag;
         v = vecs[i];
         alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
         load_valid = v.lv; load_rd = v.lrd; load_data = v.ldat;
         issue_valid = v.iv; issue_rd = v.ird; check1 = v.c1; check2 = v.c2;
         #1;
         tag = $sformatf("v%0d", i);
         chk({tag, "_alu_rdy"},  alu_ready,  v.e_ar);
         chk({tag, "_load_rdy"}, load_ready, v.e_lr);
         chk({tag, "_busy1"},    busy1,      v.e_b1);
         chk({tag, "_busy2"},    busy2,      v.e_b2);
         @(posedge clk); #1;
         chk({tag, "_wr_en"},    wr_en,      v.e_en);
         chk({tag, "_wr_idx"},   wr_idx,     v.e_idx);
         chk({tag, "_wr_data"},  wr_data,    v.e_dat);
         @(negedge clk);
      end

      // async reset with two loads buffered and a pending register
      alu_valid = 1; alu_rd = 3; alu_data = 'h70;
      load_valid = 1; load_rd = 10; load_data = 'h100;
      issue_valid = 1; issue_rd = 12; check1 = 12; check2 = 0;
      @(negedge clk);
      load_rd = 11; load_data = 'h110; issue_valid = 0;
      @(negedge clk);
      idle_inputs(); check1 = 12;
      #1;
      chk("pre_rst_load_rdy", load_ready, 0);
      chk("pre_rst_busy12",   busy1, 1);
      #1 rst_n = 0;
      #1;
      chk("mid_rst_load_rdy", load_ready, 1);
      chk("mid_rst_busy12",   busy1, 0);
      chk("mid_rst_wr_en",    wr_en, 0);
      chk("mid_rst_wr_idx",   wr_idx, 0);
      chk("mid_rst_wr_data",  wr_data, 0);
      @(negedge clk);
      rst_n = 1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst_wr_en%0d", k), wr_en, 0);
         chk($sformatf("post_rst_load_rdy%0d", k), load_ready, 1);
         chk($sformatf("post_rst_busy12_%0d", k), busy1, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
